// File: rtl/shift_sequencer.sv
// Sequences the single-step shifter for multi-bit shift/rotate instructions:
// one step per clock, feeding the shifter's registered result back until the count is spent.
module shift_sequencer (
  input  logic        CLKx4,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] A,
  input  logic [2:0]  Operation,
  input  logic        byteWord,
  input  logic [7:0]  COUNT,
  input  logic        CarryIn,
  output logic [15:0] SH_A,
  output logic [2:0]  SH_Operation,
  output logic        SH_byteWord,
  output logic        SH_carryIn,
  input  logic [15:0] SH_S,
  input  logic        SH_F_Overflow,
  input  logic        SH_F_Neg,
  input  logic        SH_F_Zero,
  input  logic        SH_F_Aux,
  input  logic        SH_F_Parity,
  input  logic        SH_F_Carry,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic        F_Overflow,
  output logic        F_Neg,
  output logic        F_Zero,
  output logic        F_Aux,
  output logic        F_Parity,
  output logic        F_Carry,
  output logic        FLAGS_UPDATE
);

  // IDLE wait | SHIFT issue steps | SETTLE take result/CF | CAPTURE take lagging flags | DONE hand off
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] a_q;
  logic [2:0]  op_q;
  logic        bw_q;
  logic        cin_q;
  logic [7:0]  remaining;
  logic        first;
  logic        zero_count;
  logic        accept;

  // BUSY still covers the DONE pulse cycle, so a new request is taken only after it.
  assign accept = (state == S_IDLE) && START && !BUSY;

  always_ff @(posedge CLKx4) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = (COUNT == 8'd0) ? S_DONE : S_SHIFT;
      S_SHIFT:   if (remaining == 8'd1) state_next = S_SETTLE;
      S_SETTLE:  state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    SH_Operation = op_q;
    SH_byteWord  = bw_q;
    SH_A         = 16'h0000;
    SH_carryIn   = 1'b0;
    case (state)
      S_SHIFT: begin
        SH_A       = first ? a_q   : SH_S;
        SH_carryIn = first ? cin_q : SH_F_Carry;
      end
      S_SETTLE: begin
        SH_A       = SH_S;
        SH_carryIn = SH_F_Carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      a_q          <= 16'h0000;
      op_q         <= 3'd0;
      bw_q         <= 1'b0;
      cin_q        <= 1'b0;
      remaining    <= 8'd0;
      first        <= 1'b0;
      zero_count   <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      FLAGS_UPDATE <= 1'b0;
      RESULT       <= 16'h0000;
      F_Overflow   <= 1'b0;
      F_Neg        <= 1'b0;
      F_Zero       <= 1'b0;
      F_Aux        <= 1'b0;
      F_Parity     <= 1'b0;
      F_Carry      <= 1'b0;
    end else begin
      DONE         <= (state == S_DONE);
      FLAGS_UPDATE <= (state == S_DONE) && !zero_count;
      BUSY         <= (state_next != S_IDLE) || (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q        <= A;
            op_q       <= Operation;
            bw_q       <= byteWord;
            cin_q      <= CarryIn;
            remaining  <= COUNT;
            first      <= 1'b1;
            zero_count <= (COUNT == 8'd0);
            if (COUNT == 8'd0) RESULT <= byteWord ? A : {8'h00, A[7:0]};
          end
        end
        S_SHIFT: begin
          remaining <= remaining - 8'd1;
          first     <= 1'b0;
        end
        S_SETTLE: begin
          RESULT  <= bw_q ? SH_S : {8'h00, SH_S[7:0]};
          F_Carry <= SH_F_Carry;
        end
        S_CAPTURE: begin
          F_Overflow <= SH_F_Overflow;
          F_Neg      <= SH_F_Neg;
          F_Zero     <= SH_F_Zero;
          F_Aux      <= SH_F_Aux;
          F_Parity   <= SH_F_Parity;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a behavioural single-step shifter closes the loop, and final
// results are compared against a closed-form shift/rotate model.
module tb_shift_sequencer;

  logic        CLKx4 = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [2:0]  Operation = 3'd0;
  logic        byteWord = 1'b0;
  logic [7:0]  COUNT = 8'd0;
  logic        CarryIn = 1'b0;
  logic [15:0] SH_A;
  logic [2:0]  SH_Operation;
  logic        SH_byteWord;
  logic        SH_carryIn;
  logic        BUSY, DONE, FLAGS_UPDATE;
  logic [15:0] RESULT;
  logic        F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry;

  // shifter model: result/carry one cycle after issue, remaining flags one cycle later
  logic [15:0] sh_s = 16'h0000;
  logic        sh_c = 1'b0, of_pend = 1'b0;
  logic        sh_of = 1'b0, sh_sf = 1'b0, sh_zf = 1'b0, sh_af = 1'b0, sh_pf = 1'b0;
  logic [17:0] st;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] sha_log [16];
  logic        shc_log [16];
  logic [2:0]  op_seen;
  logic        bw_seen;

  logic p_cf = 1'b0, p_sf = 1'b0, p_zf = 1'b0, p_pf = 1'b0, p_of = 1'b0, p_of_known = 1'b1;

  typedef struct packed {
    logic [15:0] res;
    logic        cf;
    logic        ovf;
  } exp_t;

  shift_sequencer dut (
    .CLKx4(CLKx4), .RESET(RESET), .START(START), .A(A), .Operation(Operation),
    .byteWord(byteWord), .COUNT(COUNT), .CarryIn(CarryIn),
    .SH_A(SH_A), .SH_Operation(SH_Operation), .SH_byteWord(SH_byteWord), .SH_carryIn(SH_carryIn),
    .SH_S(sh_s), .SH_F_Overflow(sh_of), .SH_F_Neg(sh_sf), .SH_F_Zero(sh_zf),
    .SH_F_Aux(sh_af), .SH_F_Parity(sh_pf), .SH_F_Carry(sh_c),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .F_Overflow(F_Overflow), .F_Neg(F_Neg), .F_Zero(F_Zero), .F_Aux(F_Aux),
    .F_Parity(F_Parity), .F_Carry(F_Carry), .FLAGS_UPDATE(FLAGS_UPDATE)
  );

  always #5 CLKx4 = ~CLKx4;

  function automatic logic [17:0] shifter_step(input logic [15:0] a, input logic ci,
                                               input logic [2:0] op, input logic bw);
    int          msb  = bw ? 15 : 7;
    logic [15:0] mask = bw ? 16'hFFFF : 16'h00FF;
    logic [15:0] v, r;
    logic        c, o;
    v = a & mask;
    case (op)
      3'd0: begin r = ((v << 1) | (v >> msb)) & mask; c = v[msb]; o = r[msb] ^ c; end
      3'd1: begin r = (v >> 1) | (16'(v[0]) << msb); c = v[0]; o = r[msb] ^ r[msb-1]; end
      3'd2: begin r = ((v << 1) | 16'(ci)) & mask; c = v[msb]; o = r[msb] ^ c; end
      3'd3: begin r = (v >> 1) | (16'(ci) << msb); c = v[0]; o = r[msb] ^ r[msb-1]; end
      3'd4, 3'd6: begin r = (v << 1) & mask; c = v[msb]; o = r[msb] ^ c; end
      3'd5: begin r = v >> 1; c = v[0]; o = v[msb]; end
      default: begin r = (v >> 1) | (16'(v[msb]) << msb); c = v[0]; o = 1'b0; end
    endcase
    return {o, c, r};
  endfunction

  always @(posedge CLKx4) begin
    st = shifter_step(SH_A, SH_carryIn, SH_Operation, SH_byteWord);
    sh_s    <= st[15:0];
    sh_c    <= st[16];
    of_pend <= st[17];
    sh_sf   <= SH_byteWord ? sh_s[15] : sh_s[7];
    sh_zf   <= SH_byteWord ? (sh_s == 16'h0000) : (sh_s[7:0] == 8'h00);
    sh_pf   <= ~^sh_s[7:0];
    sh_af   <= 1'b0;
    sh_of   <= of_pend;
  end

  function automatic int unsigned bitof(input int unsigned x, input int i);
    return (x >> i) & 1;
  endfunction

  // Closed-form final result of an n-step (n >= 1) operation.
  function automatic exp_t ref_model(input logic [2:0] op, input logic bw, input logic [15:0] a,
                                     input logic cin, input int n);
    int          w    = bw ? 16 : 8;
    int unsigned mask = (1 << w) - 1;
    int unsigned m1   = (1 << (w + 1)) - 1;
    int unsigned v    = a & mask;
    int unsigned sgn  = bitof(v, w - 1);
    int unsigned x, r;
    int          k;
    exp_t        e;
    logic        cf, ovf;
    case (op)
      3'd0: begin
        k = n % w; r = ((v << k) | (v >> (w - k))) & mask;
        cf = bitof(r, 0) != 0; ovf = (bitof(r, w - 1) != 0) ^ cf;
      end
      3'd1: begin
        k = n % w; r = ((v >> k) | (v << (w - k))) & mask;
        cf = bitof(r, w - 1) != 0; ovf = bitof(r, w - 1) != bitof(r, w - 2);
      end
      3'd2: begin
        k = n % (w + 1); x = (int'(cin) << w) | v;
        x = ((x << k) | (x >> (w + 1 - k))) & m1;
        r = x & mask; cf = bitof(x, w) != 0; ovf = (bitof(r, w - 1) != 0) ^ cf;
      end
      3'd3: begin
        k = n % (w + 1); x = (int'(cin) << w) | v;
        x = ((x >> k) | (x << (w + 1 - k))) & m1;
        r = x & mask; cf = bitof(x, w) != 0; ovf = bitof(r, w - 1) != bitof(r, w - 2);
      end
      3'd4, 3'd6: begin
        r  = (n >= w) ? 0 : ((v << n) & mask);
        cf = (n > w) ? 1'b0 : (bitof(v, w - n) != 0);
        ovf = (bitof(r, w - 1) != 0) ^ cf;
      end
      3'd5: begin
        r  = (n >= w) ? 0 : (v >> n);
        cf = (n > w) ? 1'b0 : (bitof(v, n - 1) != 0);
        ovf = sgn != 0;
      end
      default: begin
        if (n >= w) begin r = (sgn != 0) ? mask : 0; cf = sgn != 0; end
        else begin
          r  = ((v >> n) | ((sgn != 0) ? (mask << (w - n)) : 0)) & mask;
          cf = bitof(v, n - 1) != 0;
        end
        ovf = 1'b0;
      end
    endcase
    e.res = r[15:0]; e.cf = cf; e.ovf = ovf;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic bw, input logic [15:0] a,
                        input logic cin, input logic [7:0] cnt, input logic poke);
    exp_t        e;
    int          lat;
    logic        busy_ok;
    logic [15:0] mask;
    mask = bw ? 16'hFFFF : 16'h00FF;
    @(negedge CLKx4);
    START = 1'b1; A = a; Operation = op; byteWord = bw; COUNT = cnt; CarryIn = cin;
    @(posedge CLKx4);
    @(negedge CLKx4);
    START = 1'b0;
    A = 16'($urandom); Operation = 3'($urandom); byteWord = 1'($urandom);
    COUNT = 8'($urandom); CarryIn = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (DONE !== 1'b1 && lat < 300) begin
      if (lat < 16) begin sha_log[lat] = SH_A; shc_log[lat] = SH_carryIn; end
      if (lat == 0) begin op_seen = SH_Operation; bw_seen = SH_byteWord; end
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      START = (poke && lat >= 2 && lat < 6) ? 1'b1 : 1'b0;
      @(posedge CLKx4);
      lat++;
      @(negedge CLKx4);
    end
    START = 1'b0;
    check("latency", lat, (cnt == 0) ? 1 : int'(cnt) + 3);
    check("busy_during", {busy_ok, BUSY}, 2'b11);
    check("flags_update", FLAGS_UPDATE, cnt != 0);
    if (cnt == 0) begin
      check("result_cnt0", RESULT, a & mask);
      check("flags_hold", {F_Carry, F_Neg, F_Zero, F_Parity}, {p_cf, p_sf, p_zf, p_pf});
      if (p_of_known) check("of_hold", F_Overflow, p_of);
    end else begin
      e = ref_model(op, bw, a, cin, int'(cnt));
      check("sh_op", {op_seen, bw_seen}, {op, bw});
      check("result", RESULT, e.res);
      check("cf", F_Carry, e.cf);
      check("sf", F_Neg, bw ? e.res[15] : e.res[7]);
      check("zf", F_Zero, e.res == 16'h0000);
      check("pf", F_Parity, ~^e.res[7:0]);
      if (cnt == 1) check("of", F_Overflow, e.ovf);
      p_cf = e.cf; p_sf = bw ? e.res[15] : e.res[7]; p_zf = (e.res == 16'h0000);
      p_pf = ~^e.res[7:0]; p_of = e.ovf; p_of_known = (cnt == 1);
    end
    @(negedge CLKx4);
    check("done_pulse_end", {DONE, BUSY}, 2'b00);
  endtask

  task automatic watch_no_done(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge CLKx4);
      if (DONE !== 1'b0) seen = 1'b1;
    end
    check(tag, seen, 1'b0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [7:0]  r_cnt;
    int          pick;

    RESET = 1'b1;
    repeat (3) @(negedge CLKx4);
    check("rst_ctrl", {BUSY, DONE, FLAGS_UPDATE}, 3'b000);
    check("rst_result", RESULT, 16'h0000);
    check("rst_flags", {F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry}, 6'b0);
    check("rst_sh", {SH_A, SH_carryIn}, 17'h0);
    RESET = 1'b0;

    run_op(3'd4, 1'b0, 16'h0081, 1'b0, 8'd1, 1'b0);
    check("tp_shl_res", RESULT, 16'h0002);
    check("tp_shl_flags", {F_Carry, F_Zero, F_Neg, F_Overflow}, 4'b1001);

    run_op(3'd0, 1'b1, 16'h8001, 1'b0, 8'd4, 1'b0);
    check("tp_rol_sha0", sha_log[0], 16'h8001);
    check("tp_rol_sha1", sha_log[1], 16'h0003);
    check("tp_rol_sha2", sha_log[2], 16'h0006);
    check("tp_rol_sha3", sha_log[3], 16'h000C);
    check("tp_rol_res", RESULT, 16'h0018);

    run_op(3'd3, 1'b0, 16'h0001, 1'b0, 8'd9, 1'b0);
    check("tp_rcr_cin2", shc_log[1], 1'b1);
    check("tp_rcr_res", {RESULT, F_Carry}, {16'h0001, 1'b0});

    run_op(3'd7, 1'b1, 16'h8000, 1'b0, 8'd20, 1'b0);
    check("tp_sar_res", {RESULT, F_Carry, F_Neg, F_Zero}, {16'hFFFF, 3'b110});
    run_op(3'd5, 1'b0, 16'h00FF, 1'b0, 8'd8, 1'b0);
    check("tp_shr_res", {RESULT, F_Zero, F_Parity, F_Carry}, {16'h0000, 3'b111});

    run_op(3'd7, 1'b1, 16'h8000, 1'b1, 8'd1, 1'b0);
    run_op(3'd2, 1'b1, 16'h1234, 1'b1, 8'd0, 1'b0);
    check("tp_cnt0_res", RESULT, 16'h1234);

    // abort a long operation partway through its SHIFT phase
    @(negedge CLKx4);
    START = 1'b1; A = 16'h5A5A; Operation = 3'd0; byteWord = 1'b1; COUNT = 8'd200; CarryIn = 1'b0;
    @(posedge CLKx4);
    @(negedge CLKx4);
    START = 1'b0;
    repeat (9) @(negedge CLKx4);
    check("abort_busy_pre", BUSY, 1'b1);
    RESET = 1'b1;
    @(negedge CLKx4);
    RESET = 1'b0;
    check("abort_idle", {BUSY, DONE, SH_A}, 18'h0);
    check("abort_result", RESULT, 16'h0000);
    p_cf = 0; p_sf = 0; p_zf = 0; p_pf = 0; p_of = 0; p_of_known = 1'b1;
    watch_no_done(20, "abort_no_done");

    run_op(3'd1, 1'b1, 16'hC3A5, 1'b1, 8'd12, 1'b1);
    watch_no_done(20, "start_ignored");
    run_op(3'd4, 1'b1, 16'h4001, 1'b0, 8'd1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      pick = $urandom_range(0, 9);
      if (pick == 0)      r_cnt = 8'd0;
      else if (pick == 1) r_cnt = 8'($urandom_range(200, 255));
      else if (pick == 2) r_cnt = 8'd1;
      else                r_cnt = 8'($urandom_range(1, 34));
      run_op(r_op, 1'($urandom), 16'($urandom), 1'($urandom), r_cnt, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
